// File: rtl/uart_fifo_transceiver.sv
// Full-duplex UART with TX/RX FIFOs, configurable width and parity, per-frame error pulses.
// Optional feature: define UART_LOOPBACK_EN to add the `loopback` input (TX line feeds RX).

module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

module uart_fifo_transceiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef UART_LOOPBACK_EN
  input  logic                        loopback,
`endif
  input  logic                        serial_in,
  output logic                        serial_out,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        rx_frame_err,
  output logic                        rx_parity_err,
  output logic                        rx_overrun,
  output logic [2:0]                  tx_state_dbg,
  output logic [2:0]                  rx_state_dbg
);
  localparam int   DIV     = CLOCK_FREQ / BAUD_RATE;
  localparam int   HALF    = DIV / 2;
  localparam int   CW      = $clog2(DIV);
  localparam int   BW      = $clog2(DATA_BITS);
  localparam int   LW      = $clog2(FIFO_DEPTH) + 1;
  localparam bit   PAR_EN  = (PARITY != 0);
  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction

  // Reset asserts asynchronously, releases two clocks later in this domain.
  logic rst_meta, rst_n_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {rst_meta, rst_n_i} <= 2'b00;
    else      {rst_meta, rst_n_i} <= {1'b1, rst_meta};
  end

  // ---------------- TX path ----------------
  state_e                 tx_state, tx_state_nxt;
  logic [CW-1:0]          tx_cnt;
  logic [BW-1:0]          tx_bit;
  logic [DATA_BITS-1:0]   tx_shift, tx_head;
  logic                   tx_par, tx_line, tx_tick, tx_empty, tx_push, tx_pop;

  assign tx_tick  = (tx_cnt == DIV_M1);
  assign tx_empty = (tx_level == '0);
  assign tx_ready = (tx_level != LW'(FIFO_DEPTH));
  assign tx_push  = tx_valid & tx_ready;
  // Pop at IDLE, or at the end of STOP so frames run back-to-back.
  assign tx_pop   = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_tick));

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n_i), .push(tx_push), .wdata(tx_data),
    .pop(tx_pop), .rdata(tx_head), .level(tx_level)
  );

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
      else                               tx_cnt <= tx_cnt + CW'(1);
      if (tx_pop) begin
        tx_shift <= tx_head;
        tx_par   <= par_bit(tx_head);
        tx_bit   <= '0;
      end else if (tx_state == S_DATA && tx_tick) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + BW'(1);
      end
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:   if (!tx_empty) tx_state_nxt = S_START;
      S_START:  if (tx_tick) tx_state_nxt = S_DATA;
      S_DATA:   if (tx_tick && tx_bit == LAST_BIT) tx_state_nxt = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_state_nxt = S_STOP;
      S_STOP:   if (tx_tick) tx_state_nxt = tx_empty ? S_IDLE : S_START;
      default:  tx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_shift[0];
      S_PARITY: tx_line = tx_par;
      default:  tx_line = 1'b1;
    endcase
  end

  logic rx_in;
`ifdef UART_LOOPBACK_EN
  assign serial_out = loopback ? 1'b1 : tx_line;
  assign rx_in      = loopback ? tx_line : serial_in;
`else
  assign serial_out = tx_line;
  assign rx_in      = serial_in;
`endif

  // ---------------- RX path ----------------
  state_e                 rx_state, rx_state_nxt;
  logic [CW-1:0]          rx_cnt;
  logic [BW-1:0]          rx_bit;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_s1, rx_s, rx_prev, rx_par;
  logic                   rx_sample, rx_full, rx_pop, rx_push, parity_bad;
  logic                   frame_ev, parity_ev, overrun_ev;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_s1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s    <= rx_s1;
      rx_prev <= rx_s;
    end
  end

  // START waits half a bit to land on the midpoint; every later bit is a full period on.
  assign rx_sample  = (rx_state == S_START) ? (rx_cnt == HALF_M1) : (rx_cnt == DIV_M1);
  assign rx_full    = (rx_level == LW'(FIFO_DEPTH));
  assign rx_valid   = (rx_level != '0);
  assign rx_pop     = rx_valid & rx_ready;
  assign parity_bad = PAR_EN && (rx_par != par_bit(rx_shift));

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n_i), .push(rx_push), .wdata(rx_shift),
    .pop(rx_pop), .rdata(rx_data), .level(rx_level)
  );

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == S_IDLE || rx_sample) rx_cnt <= '0;
      else                                 rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == S_START) begin
        rx_bit <= '0;
      end else if (rx_state == S_DATA && rx_sample) begin
        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
        rx_bit   <= rx_bit + BW'(1);
      end
      if (rx_state == S_PARITY && rx_sample) rx_par <= rx_s;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_prev && !rx_s) rx_state_nxt = S_START;
      S_START:  if (rx_sample) rx_state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (rx_sample && rx_bit == LAST_BIT) rx_state_nxt = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (rx_sample) rx_state_nxt = S_STOP;
      S_STOP:   if (rx_sample) rx_state_nxt = S_IDLE;
      default:  rx_state_nxt = S_IDLE;
    endcase
  end

  // Stop-bit verdict; a framing error masks a parity error.
  always_comb begin
    rx_push    = 1'b0;
    frame_ev   = 1'b0;
    parity_ev  = 1'b0;
    overrun_ev = 1'b0;
    if (rx_state == S_STOP && rx_sample) begin
      if (!rx_s)           frame_ev   = 1'b1;
      else if (parity_bad) parity_ev  = 1'b1;
      else if (rx_full)    overrun_ev = 1'b1;
      else                 rx_push    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_frame_err  <= frame_ev;
      rx_parity_err <= parity_ev;
      rx_overrun    <= overrun_ev;
    end
  end

  assign tx_state_dbg = tx_state;
  assign rx_state_dbg = rx_state;
endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Bench for uart_fifo_transceiver: 8N1 main instance plus a 7-bit even-parity instance,
// queue-based expectations from a frame-level model of the serial protocol.
module tb_uart_fifo_transceiver;
  localparam int DIV   = 16;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- main DUT (8N1) ----------------
  logic [1:0] host_line = 2'b11;
  logic       serial_out, tx_ready, rx_valid, tx_valid, rx_ready;
  logic [7:0] tx_data, rx_data;
  logic [3:0] tx_level, rx_level;
  logic       frame_err, par_err, ovr;
  logic [2:0] txs, rxs;
  logic       echo_mode = 1'b0, drv_tx_valid = 1'b0, rx_ready_drv = 1'b0;
  logic [7:0] drv_tx_data = 8'h00;

  assign tx_valid = echo_mode ? rx_valid : drv_tx_valid;
  assign tx_data  = echo_mode ? rx_data  : drv_tx_data;
  assign rx_ready = echo_mode ? tx_ready : rx_ready_drv;

  uart_fifo_transceiver #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                          .FIFO_DEPTH(DEPTH), .PARITY(0)) dut (
    .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .serial_in(host_line[0]), .serial_out(serial_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level),
    .rx_frame_err(frame_err), .rx_parity_err(par_err), .rx_overrun(ovr),
    .tx_state_dbg(txs), .rx_state_dbg(rxs)
  );

  // ---------------- parity DUT (7 bits, even parity) ----------------
  logic       p_host_mode = 1'b1;
  logic       p_serial_in, p_serial_out, p_tx_ready, p_rx_valid, p_tx_valid = 1'b0;
  logic [6:0] p_tx_data = 7'h00, p_rx_data;
  logic [3:0] p_tx_level, p_rx_level;
  logic       p_frame_err, p_par_err, p_ovr;
  logic [2:0] p_txs, p_rxs;

  assign p_serial_in = p_host_mode ? host_line[1] : p_serial_out;

  uart_fifo_transceiver #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                          .FIFO_DEPTH(DEPTH), .PARITY(1)) dut_p (
    .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .serial_in(p_serial_in), .serial_out(p_serial_out),
    .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready),
    .rx_data(p_rx_data), .rx_valid(p_rx_valid), .rx_ready(1'b1),
    .tx_level(p_tx_level), .rx_level(p_rx_level),
    .rx_frame_err(p_frame_err), .rx_parity_err(p_par_err), .rx_overrun(p_ovr),
    .tx_state_dbg(p_txs), .rx_state_dbg(p_rxs)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0, n_fail = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic [6:0] rxp_exp_q[$];
  int tx_starts[$];
  int tx_start_lvl[$];
  int rst_epoch = 0;
  int frame_cnt = 0, par_cnt = 0, ovr_cnt = 0, p_frame_cnt = 0, p_par_cnt = 0, p_ovr_cnt = 0;
  int exp_frame = 0, exp_par = 0, exp_ovr = 0, exp_p_frame = 0, exp_p_par = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_errs(input string name);
    check({name, "_frame_err"},  32'(frame_cnt),   32'(exp_frame));
    check({name, "_parity_err"}, 32'(par_cnt),     32'(exp_par));
    check({name, "_overrun"},    32'(ovr_cnt),     32'(exp_ovr));
    check({name, "_p_frame"},    32'(p_frame_cnt), 32'(exp_p_frame));
    check({name, "_p_parity"},   32'(p_par_cnt),   32'(exp_p_par));
    check({name, "_p_overrun"},  32'(p_ovr_cnt),   32'd0);
  endtask

  always @(negedge clk) begin
    if (frame_err)   frame_cnt++;
    if (par_err)     par_cnt++;
    if (ovr)         ovr_cnt++;
    if (p_frame_err) p_frame_cnt++;
    if (p_par_err)   p_par_cnt++;
    if (p_ovr)       p_ovr_cnt++;
  end

  // ---------------- monitors ----------------
  initial begin : tx_mon
    logic [7:0] d;
    logic       s0, sp;
    int         ep;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && serial_out === 1'b0) begin
        ep = rst_epoch;
        tx_starts.push_back(cyc);
        tx_start_lvl.push_back(int'(tx_level));
        repeat (DIV / 2 - 1) @(negedge clk);
        s0 = serial_out;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          d[i] = serial_out;
        end
        repeat (DIV) @(negedge clk);
        sp = serial_out;
        if (ep == rst_epoch) begin
          check("tx_frame_expected", 32'(tx_exp_q.size() != 0), 32'd1);
          if (tx_exp_q.size() != 0) begin
            check("tx_start_bit", 32'(s0), 32'd0);
            check("tx_payload", 32'(d), 32'(tx_exp_q.pop_front()));
            check("tx_stop_bit", 32'(sp), 32'd1);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && rx_valid && rx_ready) begin
      check("rx_word_expected", 32'(rx_exp_q.size() != 0), 32'd1);
      if (rx_exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(rx_exp_q.pop_front()));
    end
    if (rst && p_rx_valid) begin
      check("p_rx_word_expected", 32'(rxp_exp_q.size() != 0), 32'd1);
      if (rxp_exp_q.size() != 0) check("p_rx_data", 32'(p_rx_data), 32'(rxp_exp_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_bit(input int which, input logic b);
    host_line[which] = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // par < 0 means no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int par, input logic stop);
    @(posedge clk);
    #1;
    drive_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(which, data[i]);
    if (par >= 0) drive_bit(which, par[0]);
    drive_bit(which, stop);
    host_line[which] = 1'b1;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0 || rxp_exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained"},
          32'(tx_exp_q.size() == 0 && rx_exp_q.size() == 0 && rxp_exp_q.size() == 0), 32'd1);
  endtask

  initial begin : watchdog
    #600_000;
    n_fail++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [7:0] b;
    logic [6:0] w;
    int         found;
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset_serial_out", 32'(serial_out), 32'd1);
    check("reset_tx_ready",   32'(tx_ready),   32'd1);
    check("reset_rx_valid",   32'(rx_valid),   32'd0);
    check("reset_tx_level",   32'(tx_level),   32'd0);
    check("reset_rx_level",   32'(rx_level),   32'd0);
    check("reset_p_serial_out", 32'(p_serial_out), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Echo of 0x61..0x6A, then random bytes with random gaps.
    echo_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = 8'h61 + 8'(i);
      rx_exp_q.push_back(b);
      tx_exp_q.push_back(b);
      send_frame(0, {1'b0, b}, 8, -1, 1'b1);
    end
    wait_drained("echo_fixed", 20000);
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_exp_q.push_back(b);
      tx_exp_q.push_back(b);
      send_frame(0, {1'b0, b}, 8, -1, 1'b1);
      repeat ($urandom_range(0, 3 * DIV)) @(posedge clk);
    end
    wait_drained("echo_random", 20000);
    check_errs("echo");
    repeat (DIV) @(posedge clk);
    #1 echo_mode = 1'b0;

    // Overrun: consumer stalled, one more frame than the FIFO holds.
    rx_ready_drv = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
      else exp_ovr++;
      send_frame(0, {1'b0, b}, 8, -1, 1'b1);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("overrun_rx_level", 32'(rx_level), 32'(DEPTH));
    check_errs("overrun");
    @(posedge clk);
    #1 rx_ready_drv = 1'b1;
    wait_drained("overrun_drain", 200);

    // Bad stop bit, then a short glitch on an idle line.
    exp_frame++;
    send_frame(0, 9'h03C, 8, -1, 1'b0);
    repeat (DIV) @(posedge clk);
    @(negedge clk);
    check("frame_err_rx_level", 32'(rx_level), 32'd0);
    check_errs("frame_err");
    @(posedge clk);
    #1 host_line[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 host_line[0] = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    @(negedge clk);
    check("glitch_rx_level", 32'(rx_level), 32'd0);
    check_errs("glitch");

    // TX burst: fill the FIFO as fast as it accepts.
    tx_starts.delete();
    tx_start_lvl.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      case (i)
        0: b = 8'h00;
        1: b = 8'h55;
        2: b = 8'hAA;
        3: b = 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      tx_exp_q.push_back(b);
      drv_tx_data  = b;
      drv_tx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    drv_tx_valid = 1'b0;
    check("burst_tx_ready_full", 32'(tx_ready), 32'd0);
    check("burst_tx_level_full", 32'(tx_level), 32'(DEPTH));
    wait_drained("burst", 20000);
    check("burst_frame_count", 32'(tx_starts.size()), 32'(DEPTH + 1));
    for (int k = 1; k < tx_starts.size(); k++) begin
      check("burst_back_to_back", 32'(tx_starts[k] - tx_starts[k-1]), 32'(10 * DIV));
      check("burst_level_countdown", 32'(tx_start_lvl[k]), 32'(DEPTH - k));
    end

    // Parity instance: bad parity, good frame, bad stop with bad parity.
    exp_p_par++;
    send_frame(1, 9'h03C, 7, 1, 1'b1);
    rxp_exp_q.push_back(7'h3C);
    send_frame(1, 9'h03C, 7, ($countones(7'h3C) % 2), 1'b1);
    exp_p_frame++;
    send_frame(1, 9'h03C, 7, 1, 1'b0);
    wait_drained("parity_host", 4000);
    check_errs("parity_host");

    // Parity instance looped on itself: its TX parity must satisfy its RX check.
    repeat (DIV) @(posedge clk);
    #1 p_host_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w = 7'($urandom_range(0, 127));
      rxp_exp_q.push_back(w);
      p_tx_data  = w;
      p_tx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    p_tx_valid = 1'b0;
    wait_drained("parity_loop", 20000);
    check_errs("parity_loop");

    // Reset in the middle of a TX frame.
    drv_tx_data  = 8'h5A;
    drv_tx_valid = 1'b1;
    @(posedge clk);
    #1 drv_tx_valid = 1'b0;
    found = 0;
    for (int n = 0; n < 4 * DIV; n++) begin
      @(negedge clk);
      if (serial_out == 1'b0) begin
        found = 1;
        break;
      end
    end
    check("midframe_start_seen", 32'(found), 32'd1);
    repeat (3 * DIV) @(posedge clk);
    #1;
    rst_epoch++;
    rst = 1'b0;
    #1;
    check("midframe_serial_out", 32'(serial_out), 32'd1);
    check("midframe_tx_level",   32'(tx_level),   32'd0);
    check("midframe_tx_ready",   32'(tx_ready),   32'd1);
    check("midframe_rx_valid",   32'(rx_valid),   32'd0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    repeat (12 * DIV) @(posedge clk);
    @(negedge clk);
    check("post_reset_serial_out", 32'(serial_out), 32'd1);
    check("post_reset_tx_level",   32'(tx_level),   32'd0);
    wait_drained("final", 10);
    check_errs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
